// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and widths for the MEM pipeline stage
package mips_pipe_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/gnt/rvalid bus
// master: stage side (drives request, address, write data, write enable)
// slave : memory side (drives grant, read-valid, read data)
interface mem_access_stage_if;

  logic                             dmem_req;
  logic                             dmem_we;
  logic [mips_pipe_pkg::WORD_W-1:0] dmem_addr;
  logic [mips_pipe_pkg::WORD_W-1:0] dmem_wdata;
  logic                             dmem_gnt;
  logic                             dmem_rvalid;
  logic [mips_pipe_pkg::WORD_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_access_stage_bus_ctrl.sv
// rtl/mem_access_stage_bus_ctrl.sv - data-memory access FSM with timeout
// clk/rst_n      : clock (falling-edge state), async active-low reset
// start          : aligned load/store presented while idle
// is_read/is_write, addr, wdata : access description from EX/MEM
// bus            : memory bus (master side)
// busy           : an access is outstanding (REQ or WAIT)
// done/abort     : access completes / is abandoned on the coming edge
// stall, rdata   : upstream hold, read data from the bus
module dmem_bus_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_read,
  input  logic               is_write,
  input  logic [WORD_W-1:0]  addr,
  input  logic [WORD_W-1:0]  wdata,
  mem_access_stage_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               abort,
  output logic               stall,
  output logic [WORD_W-1:0]  rdata
);

  localparam logic [1:0]       S_IDLE   = IDLE;
  localparam logic [1:0]       S_REQ    = REQ;
  localparam logic [1:0]       S_WAIT   = WAIT;
  // Abort fires in the cycle that would make the count reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             req;
  logic             accepted;

  // A store finishes on grant; a load needs grant and data together.
  assign accepted = bus.dmem_gnt && (!is_read || bus.dmem_rvalid);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req        = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (start) begin
          req = 1'b1;
          if (accepted)          done       = 1'b1;
          else if (bus.dmem_gnt) state_next = S_WAIT;
          else                   state_next = S_REQ;
        end
      end
      S_REQ: begin
        req      = 1'b1;
        cnt_next = cnt + 1'b1;
        if (accepted) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end else if (bus.dmem_gnt) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt + 1'b1;
        if (bus.dmem_rvalid) begin
          done       = 1'b1;
          state_next = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign busy = (state != S_IDLE);
  // Releasing stall on abort lets upstream move past the failed access.
  assign stall = rst_n && (busy || start) && !done && !abort;

  assign bus.dmem_req   = rst_n && req;
  assign bus.dmem_we    = is_write && !is_read;
  assign bus.dmem_addr  = addr;
  assign bus.dmem_wdata = wdata;
  assign rdata          = bus.dmem_rdata;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data access, misalignment check, MEM/WB register
// CLK/RSTn          : clock (falling-edge state), async active-low reset
// *3_4 inputs       : EX/MEM register outputs
// dmem              : data-memory bus (master side)
// stall_mem         : hold EX/MEM and earlier stages
// mem_fault         : one-cycle pulse on misaligned or timed-out access
// *4_5 outputs      : MEM/WB register
module mem_access_stage
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [WORD_W-1:0]     ALUresult3_4,
  input  logic [WORD_W-1:0]     store_data3_4,
  input  logic [REG_ADDR_W-1:0] Wreg_addr3_4,
  input  logic                  RegWrite3_4,
  input  logic                  MemWrite3_4,
  input  logic                  MemRead3_4,
  input  logic                  MemtoReg3_4,
  mem_access_stage_if.master    dmem,
  output logic                  stall_mem,
  output logic                  mem_fault,
  output logic [WORD_W-1:0]     rdata4_5,
  output logic [WORD_W-1:0]     ALUresult4_5,
  output logic [REG_ADDR_W-1:0] Wreg_addr4_5,
  output logic                  RegWrite4_5,
  output logic                  MemtoReg4_5
);

  logic              op, aligned, start, misaligned, is_store;
  logic              busy, done, abort, capture;
  logic [WORD_W-1:0] bus_rdata;

  assign op         = MemRead3_4 || MemWrite3_4;
  assign aligned    = (ALUresult3_4[1:0] == 2'b00);
  assign start      = op && aligned && !busy;
  assign misaligned = op && !aligned && !busy;
  assign is_store   = MemWrite3_4 && !MemRead3_4;
  // Non-memory ops pass straight through; memory ops only on completion.
  assign capture    = done || (!busy && !op);
  assign mem_fault  = RSTn && (misaligned || abort);

  dmem_bus_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_bus_ctrl (
    .clk      (CLK),
    .rst_n    (RSTn),
    .start    (start),
    .is_read  (MemRead3_4),
    .is_write (MemWrite3_4),
    .addr     (ALUresult3_4),
    .wdata    (store_data3_4),
    .bus      (dmem),
    .busy     (busy),
    .done     (done),
    .abort    (abort),
    .stall    (stall_mem),
    .rdata    (bus_rdata)
  );

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rdata4_5     <= '0;
      ALUresult4_5 <= '0;
      Wreg_addr4_5 <= '0;
      RegWrite4_5  <= 1'b0;
      MemtoReg4_5  <= 1'b0;
    end else if (capture) begin
      rdata4_5     <= (done && MemRead3_4) ? bus_rdata : '0;
      ALUresult4_5 <= ALUresult3_4;
      Wreg_addr4_5 <= Wreg_addr3_4;
      RegWrite4_5  <= RegWrite3_4 && !is_store;
      MemtoReg4_5  <= MemtoReg3_4;
    end else begin
      // Bubble: only the write enable matters downstream.
      RegWrite4_5  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  logic        CLK  = 1'b1;
  logic        RSTn = 1'b0;
  logic [31:0] ALUresult3_4, store_data3_4;
  logic [4:0]  Wreg_addr3_4;
  logic        RegWrite3_4, MemWrite3_4, MemRead3_4, MemtoReg3_4;
  logic        stall_mem, mem_fault;
  logic [31:0] rdata4_5, ALUresult4_5;
  logic [4:0]  Wreg_addr4_5;
  logic        RegWrite4_5, MemtoReg4_5;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .ALUresult3_4  (ALUresult3_4),
    .store_data3_4 (store_data3_4),
    .Wreg_addr3_4  (Wreg_addr3_4),
    .RegWrite3_4   (RegWrite3_4),
    .MemWrite3_4   (MemWrite3_4),
    .MemRead3_4    (MemRead3_4),
    .MemtoReg3_4   (MemtoReg3_4),
    .dmem          (dmem),
    .stall_mem     (stall_mem),
    .mem_fault     (mem_fault),
    .rdata4_5      (rdata4_5),
    .ALUresult4_5  (ALUresult4_5),
    .Wreg_addr4_5  (Wreg_addr4_5),
    .RegWrite4_5   (RegWrite4_5),
    .MemtoReg4_5   (MemtoReg4_5)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        rw;
    logic        m2r;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wreg,
                       input logic rw, input logic mw, input logic mr, input logic m2r);
    ALUresult3_4  = alu;
    store_data3_4 = sd;
    Wreg_addr3_4  = wreg;
    RegWrite3_4   = rw;
    MemWrite3_4   = mw;
    MemRead3_4    = mr;
    MemtoReg3_4   = m2r;
  endtask

  task automatic bus_drive(input logic gnt, input logic rvalid, input logic [31:0] rdata);
    dmem.dmem_gnt    = gnt;
    dmem.dmem_rvalid = rvalid;
    dmem.dmem_rdata  = rdata;
  endtask

  task automatic push(input logic [31:0] rdata, input logic [31:0] alu, input logic [4:0] wreg,
                      input logic rw, input logic m2r);
    wb_t e;
    e.rdata = rdata; e.alu = alu; e.wreg = wreg; e.rw = rw; e.m2r = m2r;
    sb.push_back(e);
  endtask

  task automatic retire(input string tag);
    wb_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_pending observed=0 expected=1", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk32({tag, "_rdata"}, rdata4_5, e.rdata);
      chk32({tag, "_alu"}, ALUresult4_5, e.alu);
      chk32({tag, "_wreg"}, 32'(Wreg_addr4_5), 32'(e.wreg));
      chk1({tag, "_rw"}, RegWrite4_5, e.rw);
      chk1({tag, "_m2r"}, MemtoReg4_5, e.m2r);
    end
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic stall, input logic fault);
    chk1({tag, "_req"}, dmem.dmem_req, req);
    chk1({tag, "_stall"}, stall_mem, stall);
    chk1({tag, "_fault"}, mem_fault, fault);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_drive(1'b0, 1'b0, 32'h0);
    #1;
    chk_bus("reset", 1'b0, 1'b0, 1'b0);
    chk1("reset_rw", RegWrite4_5, 1'b0);
    chk32("reset_rdata", rdata4_5, 32'h0);
    chk32("reset_alu", ALUresult4_5, 32'h0);

    // plain ALU op passes in one cycle
    @(posedge CLK); RSTn = 1'b1;
    drive(32'h0000_1234, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk_bus("alu", 1'b0, 1'b0, 1'b0);
    push(32'h0, 32'h0000_1234, 5'd4, 1'b1, 1'b0);

    // load, grant and data in the same cycle
    @(posedge CLK);
    drive(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    bus_drive(1'b1, 1'b1, 32'hDEAD_BEEF);
    #2; retire("alu");
    chk_bus("ld0", 1'b1, 1'b0, 1'b0);
    chk1("ld0_we", dmem.dmem_we, 1'b0);
    chk32("ld0_addr", dmem.dmem_addr, 32'h0000_0100);
    push(32'hDEAD_BEEF, 32'h0000_0100, 5'd7, 1'b1, 1'b1);

    // store, grant after three cycles, RegWrite forced off
    @(posedge CLK);
    drive(32'h0000_0040, 32'h1234_5678, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    bus_drive(1'b0, 1'b0, 32'h0);
    #2; retire("ld0");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(posedge CLK); #2;
        chk1("st_bubble", RegWrite4_5, 1'b0);
      end
      chk_bus("st_wait", 1'b1, 1'b1, 1'b0);
      chk1("st_we", dmem.dmem_we, 1'b1);
      chk32("st_addr", dmem.dmem_addr, 32'h0000_0040);
      chk32("st_wdata", dmem.dmem_wdata, 32'h1234_5678);
    end
    @(posedge CLK); bus_drive(1'b1, 1'b0, 32'h0);
    #2; chk_bus("st_gnt", 1'b1, 1'b0, 1'b0);
    chk1("st_gnt_bubble", RegWrite4_5, 1'b0);
    push(32'h0, 32'h0000_0040, 5'd3, 1'b0, 1'b0);

    // load, grant then data two cycles later
    @(posedge CLK);
    drive(32'h0000_0200, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    bus_drive(1'b1, 1'b0, 32'h0);
    #2; retire("store");
    chk_bus("ldw_gnt", 1'b1, 1'b1, 1'b0);
    @(posedge CLK); bus_drive(1'b0, 1'b0, 32'h0);
    #2; chk_bus("ldw_wait", 1'b0, 1'b1, 1'b0);
    chk1("ldw_bubble", RegWrite4_5, 1'b0);
    @(posedge CLK); bus_drive(1'b0, 1'b1, 32'hCAFE_F00D);
    #2; chk_bus("ldw_rvalid", 1'b0, 1'b0, 1'b0);
    push(32'hCAFE_F00D, 32'h0000_0200, 5'd9, 1'b1, 1'b1);

    // misaligned load
    @(posedge CLK);
    drive(32'h0000_0102, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    bus_drive(1'b0, 1'b0, 32'h0);
    #2; retire("ldw");
    chk_bus("mis", 1'b0, 1'b0, 1'b1);
    @(posedge CLK);
    drive(32'h0000_0077, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk_bus("mis_after", 1'b0, 1'b0, 1'b0);
    chk1("mis_bubble", RegWrite4_5, 1'b0);
    push(32'h0, 32'h0000_0077, 5'd6, 1'b1, 1'b0);

    // timeout: grant never arrives
    @(posedge CLK);
    drive(32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    #2; retire("alu2");
    chk_bus("to_start", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #2;
      chk_bus("to_req", 1'b1, 1'b1, 1'b0);
    end
    @(posedge CLK); #2;
    chk1("to_abort_fault", mem_fault, 1'b1);
    chk1("to_abort_stall", stall_mem, 1'b0);
    @(posedge CLK);
    drive(32'h0000_0088, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_drive(1'b1, 1'b1, 32'h5555_5555);
    #2; chk_bus("to_late", 1'b0, 1'b0, 1'b0);
    chk1("to_bubble", RegWrite4_5, 1'b0);
    push(32'h0, 32'h0000_0088, 5'd10, 1'b1, 1'b0);

    // reset while waiting for read data
    @(posedge CLK);
    drive(32'h0000_0400, 32'h0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    bus_drive(1'b1, 1'b0, 32'h0);
    #2; retire("alu3");
    chk1("rw_gnt_stall", stall_mem, 1'b1);
    @(posedge CLK); bus_drive(1'b0, 1'b0, 32'h0);
    #2; chk_bus("rw_wait", 1'b0, 1'b1, 1'b0);
    #1 RSTn = 1'b0;
    #1; chk_bus("rw_reset", 1'b0, 1'b0, 1'b0);
    chk32("rw_reset_alu", ALUresult4_5, 32'h0);
    chk32("rw_reset_wreg", 32'(Wreg_addr4_5), 32'h0);
    chk1("rw_reset_m2r", MemtoReg4_5, 1'b0);
    @(posedge CLK); RSTn = 1'b1;
    drive(32'h0000_0099, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk_bus("post_rst", 1'b0, 1'b0, 1'b0);
    push(32'h0, 32'h0000_0099, 5'd12, 1'b1, 1'b0);
    @(posedge CLK);
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; retire("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
